// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner: FSM state encoding,
// number of stimulus vectors and the vector index width.
package tt_scan_pkg;
    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/truth_table_scanner_if.sv
// Bundle of the scanner's control, stimulus, response and result signals.
// slave is the scanner side, master is the side that owns start and the responses.
interface truth_table_scanner_if;
    import tt_scan_pkg::*;

    logic                   start;
    logic                   y_a;
    logic                   y_b;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] tt_a;
    logic [NUM_VECTORS-1:0] tt_b;
    logic [3:0]             mismatch_count;
    logic                   mismatch;
    logic [IDX_W-1:0]       first_mismatch_idx;

    modport slave (
        input  start, y_a, y_b,
        output a, b, c, busy, done, tt_a, tt_b,
               mismatch_count, mismatch, first_mismatch_idx
    );

    modport master (
        output start, y_a, y_b,
        input  a, b, c, busy, done, tt_a, tt_b,
               mismatch_count, mismatch, first_mismatch_idx
    );
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle counter: counts enabled cycles from zero and flags the last one,
// so the owner holds a vector for exactly SETTLE_CYCLES cycles.
module settle_timer #(
    parameter int SETTLE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == 8'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c} through all eight vectors, lets each settle, then records both
// implementations' responses and tracks where they disagree.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_scanner_if.slave bus
);
    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_VECTORS-1:0] tt_a_q, tt_a_d;
    logic [NUM_VECTORS-1:0] tt_b_q, tt_b_d;
    logic [3:0]             mm_cnt_q, mm_cnt_d;
    logic [IDX_W-1:0]       first_q, first_d;
    logic                   expired;
    logic                   in_drive;
    logic                   busy;
    logic [IDX_W-1:0]       vec;

    assign in_drive = (state_q == DRIVE);

    // Cleared outside DRIVE so every vector starts its settle window at zero.
    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_drive),
        .enable  (in_drive),
        .expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_a_d   = tt_a_q;
        tt_b_d   = tt_b_q;
        mm_cnt_d = mm_cnt_q;
        first_d  = first_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    tt_a_d   = '0;
                    tt_b_d   = '0;
                    mm_cnt_d = 4'd0;
                    first_d  = '0;
                end
            end
            DRIVE: begin
                if (expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_a_d[idx_q] = bus.y_a;
                tt_b_d[idx_q] = bus.y_b;
                if (bus.y_a != bus.y_b) begin
                    if (mm_cnt_q == 4'd0) begin
                        first_d = idx_q;
                    end
                    if (mm_cnt_q != 4'(NUM_VECTORS)) begin
                        mm_cnt_d = mm_cnt_q + 4'd1;
                    end
                end
                if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tt_a_q   <= '0;
            tt_b_q   <= '0;
            mm_cnt_q <= 4'd0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tt_a_q   <= tt_a_d;
            tt_b_q   <= tt_b_d;
            mm_cnt_q <= mm_cnt_d;
            first_q  <= first_d;
        end
    end

    assign busy = (state_q == DRIVE) || (state_q == SAMPLE);
    assign vec  = busy ? idx_q : '0;

    assign bus.a                  = vec[2];
    assign bus.b                  = vec[1];
    assign bus.c                  = vec[0];
    assign bus.busy               = busy;
    assign bus.done               = (state_q == DONE);
    assign bus.tt_a               = tt_a_q;
    assign bus.tt_b               = tt_b_q;
    assign bus.mismatch_count     = mm_cnt_q;
    assign bus.mismatch           = (mm_cnt_q != 4'd0);
    assign bus.first_mismatch_idx = first_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: two scanners (SETTLE_CYCLES 10 and 1) fed by a behavioural
// response model selectable per scenario.
module tb_truth_table_scanner;
    import tt_scan_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mode10 = 0;
    int   mode1  = 0;

    always #5 clk = ~clk;

    truth_table_scanner_if bus10();
    truth_table_scanner_if bus1();

    truth_table_scanner #(.SETTLE_CYCLES(10)) dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // mode 0: both majority; 1: y_b flipped on vector 5; 2: y_a=1, y_b=0
    function automatic logic [1:0] model_y(input int mode, input logic a, input logic b, input logic c);
        logic m;
        m = (a & b) | (a & c) | (b & c);
        case (mode)
            1:       return {m, m ^ ({a, b, c} == 3'd5)};
            2:       return 2'b10;
            default: return {m, m};
        endcase
    endfunction

    assign {bus10.y_a, bus10.y_b} = model_y(mode10, bus10.a, bus10.b, bus10.c);
    assign {bus1.y_a, bus1.y_b}   = model_y(mode1, bus1.a, bus1.b, bus1.c);

    // Pulses start on the 10-cycle scanner and returns edges from accept to done
    // (-1 on timeout); optionally re-pulses start after edge restart_at.
    task automatic scan10(input int restart_at, output int edges);
        edges = -1;
        @(negedge clk);
        bus10.start = 1'b1;
        @(posedge clk);
        #1;
        bus10.start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus10.done) begin
                edges = n;
                break;
            end
            bus10.start = (n == restart_at);
        end
        bus10.start = 1'b0;
        if (edges < 0) $display("FAIL done_timeout: done never rose within 200 edges");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus10.busy, bus10.done, bus10.a, bus10.b, bus10.c} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy,done,a,b,c=%b required 00000",
                     {bus10.busy, bus10.done, bus10.a, bus10.b, bus10.c});
        end
        checks++;
        if ({bus10.tt_a, bus10.tt_b} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_tt: tt_a=%h tt_b=%h required 00 00", bus10.tt_a, bus10.tt_b);
        end
        checks++;
        if ({bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mm: count=%0d mismatch=%b first=%0d required 0 0 0",
                     bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus10.busy, bus10.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: busy,done=%b required 00", {bus10.busy, bus10.done});
        end
        $display("test_reset: done");
    endtask

    task automatic test_majority();
        int e;
        mode10 = 0;
        scan10(0, e);
        checks++;
        if (e !== 88) begin
            errors++;
            $display("FAIL maj_latency: done after %0d edges required 88", e);
        end
        checks++;
        if ({bus10.tt_a, bus10.tt_b} !== 16'hE8E8) begin
            errors++;
            $display("FAIL maj_tt: tt_a=%h tt_b=%h required e8 e8", bus10.tt_a, bus10.tt_b);
        end
        checks++;
        if ({bus10.mismatch_count, bus10.mismatch} !== 5'b0) begin
            errors++;
            $display("FAIL maj_mm: count=%0d mismatch=%b required 0 0", bus10.mismatch_count, bus10.mismatch);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({bus10.done, bus10.busy, bus10.tt_a} !== {2'b10, 8'hE8}) begin
            errors++;
            $display("FAIL done_hold: done=%b busy=%b tt_a=%h required 1 0 e8",
                     bus10.done, bus10.busy, bus10.tt_a);
        end
        $display("test_majority: edges=%0d tt_a=%h tt_b=%h", e, bus10.tt_a, bus10.tt_b);
    endtask

    task automatic test_single_mismatch();
        int e;
        mode10 = 1;
        scan10(0, e);
        checks++;
        if ({bus10.tt_a, bus10.tt_b} !== 16'hE8C8) begin
            errors++;
            $display("FAIL one_mm_tt: tt_a=%h tt_b=%h required e8 c8", bus10.tt_a, bus10.tt_b);
        end
        checks++;
        if ({bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx} !== {4'd1, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL one_mm_stats: count=%0d mismatch=%b first=%0d required 1 1 5",
                     bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx);
        end
        $display("test_single_mismatch: tt_b=%h count=%0d", bus10.tt_b, bus10.mismatch_count);
    endtask

    task automatic test_constant();
        int e;
        mode10 = 2;
        scan10(0, e);
        checks++;
        if ({bus10.tt_a, bus10.tt_b} !== 16'hFF00) begin
            errors++;
            $display("FAIL const_tt: tt_a=%h tt_b=%h required ff 00", bus10.tt_a, bus10.tt_b);
        end
        checks++;
        if ({bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx} !== {4'd8, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL const_stats: count=%0d mismatch=%b first=%0d required 8 1 0",
                     bus10.mismatch_count, bus10.mismatch, bus10.first_mismatch_idx);
        end
        $display("test_constant: count=%0d", bus10.mismatch_count);
    endtask

    task automatic test_restart_ignored();
        int e;
        mode10 = 0;
        scan10(35, e);
        checks++;
        if (e !== 88) begin
            errors++;
            $display("FAIL restart_latency: done after %0d edges required 88", e);
        end
        checks++;
        if ({bus10.tt_a, bus10.tt_b, bus10.mismatch_count} !== {16'hE8E8, 4'd0}) begin
            errors++;
            $display("FAIL restart_results: tt_a=%h tt_b=%h count=%0d required e8 e8 0",
                     bus10.tt_a, bus10.tt_b, bus10.mismatch_count);
        end
        $display("test_restart_ignored: edges=%0d", e);
    endtask

    task automatic test_reset_mid_scan();
        int e;
        mode10 = 0;
        @(negedge clk);
        bus10.start = 1'b1;
        @(posedge clk);
        #1;
        bus10.start = 1'b0;
        repeat (47) @(posedge clk);
        #1;
        checks++;
        if ({bus10.busy, bus10.a, bus10.b, bus10.c, bus10.tt_a} !== {4'b1100, 8'h08}) begin
            errors++;
            $display("FAIL mid_scan_state: busy=%b abc=%b tt_a=%h required 1 100 08",
                     bus10.busy, {bus10.a, bus10.b, bus10.c}, bus10.tt_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus10.busy, bus10.done, bus10.a, bus10.b, bus10.c, bus10.tt_a, bus10.tt_b} !== 21'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b abc=%b tt_a=%h tt_b=%h required all zero",
                     bus10.busy, bus10.done, {bus10.a, bus10.b, bus10.c}, bus10.tt_a, bus10.tt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus10.busy, bus10.done} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle: busy,done=%b required 00", {bus10.busy, bus10.done});
        end
        scan10(0, e);
        checks++;
        if ({e == 88, bus10.tt_a, bus10.tt_b, bus10.mismatch_count} !== {1'b1, 16'hE8E8, 4'd0}) begin
            errors++;
            $display("FAIL post_reset_scan: edges=%0d tt_a=%h tt_b=%h count=%0d required 88 e8 e8 0",
                     e, bus10.tt_a, bus10.tt_b, bus10.mismatch_count);
        end
        $display("test_reset_mid_scan: rescan edges=%0d", e);
    endtask

    task automatic test_settle1();
        int e;
        mode1 = 2;
        e = -1;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                e = n;
                break;
            end
        end
        checks++;
        if ({e == 16, bus1.tt_a, bus1.tt_b, bus1.mismatch_count} !== {1'b1, 16'hFF00, 4'd8}) begin
            errors++;
            $display("FAIL s1_const: edges=%0d tt_a=%h tt_b=%h count=%0d required 16 ff 00 8",
                     e, bus1.tt_a, bus1.tt_b, bus1.mismatch_count);
        end
        mode1 = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        checks++;
        if ({bus1.busy, bus1.done, bus1.tt_a, bus1.tt_b, bus1.mismatch_count, bus1.mismatch} !== {2'b10, 21'b0}) begin
            errors++;
            $display("FAIL s1_restart_clear: busy=%b done=%b tt_a=%h tt_b=%h count=%0d mismatch=%b required 1 0 00 00 0 0",
                     bus1.busy, bus1.done, bus1.tt_a, bus1.tt_b, bus1.mismatch_count, bus1.mismatch);
        end
        e = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                checks++;
                if ({bus1.a, bus1.b, bus1.c} !== 3'd1) begin
                    errors++;
                    $display("FAIL s1_vector_len: abc=%b two edges after accept required 001",
                             {bus1.a, bus1.b, bus1.c});
                end
            end
            if (bus1.done) begin
                e = n;
                break;
            end
        end
        checks++;
        if ({e == 16, bus1.tt_a, bus1.tt_b, bus1.mismatch_count} !== {1'b1, 16'hE8E8, 4'd0}) begin
            errors++;
            $display("FAIL s1_maj: edges=%0d tt_a=%h tt_b=%h count=%0d required 16 e8 e8 0",
                     e, bus1.tt_a, bus1.tt_b, bus1.mismatch_count);
        end
        $display("test_settle1: edges=%0d tt_a=%h", e, bus1.tt_a);
    endtask

    initial begin
        bus10.start = 1'b0;
        bus1.start  = 1'b0;
        test_reset();
        test_majority();
        test_single_mismatch();
        test_constant();
        test_restart_ignored();
        test_reset_mid_scan();
        test_settle1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 10, is the number of cycles each input vector is held before its response is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a full scan; sampled only in IDLE or DONE.
REQ-005 y_a  input  1  response of implementation A (e.g. NAND-only form).
REQ-006 y_b  input  1  response of implementation B (e.g. NOR-only form).
REQ-007 a, b, c  output  1 each  stimulus bits driven to both implementations; a is the MSB of the vector index {a,b,c}.
REQ-008 busy  output  1  high in DRIVE and SAMPLE.
REQ-009 done  output  1  high in DONE.
REQ-010 tt_a  output  8  captured truth table of y_a; bit i holds the response to vector i.
REQ-011 tt_b  output  8  captured truth table of y_b, same bit ordering.
REQ-012 mismatch_count  output  4  number of vectors where y_a != y_b, range 0..8.
REQ-013 mismatch  output  1  high when mismatch_count != 0.
REQ-014 first_mismatch_idx  output  3  lowest vector index that mismatched; 0 when mismatch is low.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-016 In IDLE or DONE with start=1, the next edge SHALL enter DRIVE with idx=0 and settle count 0, and SHALL clear tt_a, tt_b, mismatch_count and first_mismatch_idx.
REQ-017 In DRIVE, the settle count SHALL increment each cycle; when the count equals SETTLE_CYCLES-1, the next state SHALL be SAMPLE.
REQ-018 On the edge leaving SAMPLE: y_a goes to tt_a[idx], y_b goes to tt_b[idx]; if y_a != y_b, mismatch_count increments, and first_mismatch_idx loads idx if this is the first mismatch.
REQ-019 From SAMPLE: idx<7 leads to DRIVE with idx+1 and count 0; idx==7 leads to DONE with idx cleared to 0.
REQ-020 {a,b,c} SHALL equal idx in DRIVE and SAMPLE, and SHALL be 3'b000 in IDLE and DONE.
REQ-021 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles; done SHALL rise 8*(SETTLE_CYCLES+1) edges after the edge that accepted start.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 DONE SHALL persist with all results stable until start or reset.
REQ-024 mismatch_count SHALL NOT wrap; its maximum of 8 fits the 4-bit width.

Reset
REQ-025 While rst_n=0, asynchronously: state IDLE, idx 0, count 0, and outputs a=b=c=0, busy=0, done=0, tt_a=tt_b=8'h00, mismatch_count=0, mismatch=0, first_mismatch_idx=0.
REQ-026 Reset mid-scan SHALL abandon the scan with no partial results retained; the first edge after release SHALL remain in IDLE unless start=1.

Structure
REQ-027 Package tt_scan_pkg SHALL hold the state enum, NUM_VECTORS=8 and the index width constant (3).
REQ-028 The settle counter SHALL be a sub-module settle_timer with inputs clear and enable and output expired.

Verification
REQ-029 Both inputs driven by the majority of a,b,c with SETTLE_CYCLES=10, start pulsed once: tt_a=tt_b=8'hE8, mismatch_count=0, mismatch=0, and done rises 88 edges after start.
REQ-030 y_a = majority, y_b = majority XOR (idx==5): tt_b=8'hC8, mismatch_count=1, first_mismatch_idx=5, mismatch=1.
REQ-031 y_a=1, y_b=0 constant: tt_a=8'hFF, tt_b=8'h00, mismatch_count=8, first_mismatch_idx=0.
REQ-032 start pulsed again at vector 3 mid-scan: scan continues unchanged, and done rises at the original 88-edge point.
REQ-033 rst_n asserted during vector 4: all outputs return to reset values immediately; a new start then gives a full scan with correct results.
REQ-034 SETTLE_CYCLES=1: each vector lasts 2 cycles, done rises 16 edges after start, and a restart from DONE clears the previous results on the accept edge.
